// File: rtl/tick_event_pkg.sv
// Shared types and widths for the tick event generator.
package tick_event_pkg;

  localparam int unsigned GAP_BITS = 17;
  localparam int unsigned EVT_BITS = 8;

  // Encodings are pinned so they match the legacy state constants.
  typedef enum logic [1:0] {
    COUNT = 2'd0,
    REQ   = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/tick_period_mon.sv
// Tick period monitor: flags ticks whose spacing differs from PERIOD and
// flags a missing tick once, PERIOD+1 cycles after the last one.
module tick_period_mon
  import tick_event_pkg::*;
#(
  parameter int unsigned PERIOD = 100001
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  output logic per_err
);

  localparam logic [GAP_BITS:0] PER_EXP  = (GAP_BITS + 1)'(PERIOD);
  localparam logic [GAP_BITS:0] PER_LATE = (GAP_BITS + 1)'(PERIOD + 1);

  logic [GAP_BITS-1:0] gap;
  logic                armed;
  logic                late;
  logic [GAP_BITS:0]   since;
  logic                bad_tick;
  logic                timeout;

  // gap is cleared on the tick edge, so the cycle count seen at this edge is gap+1.
  assign since    = {1'b0, gap} + 1'b1;
  assign bad_tick = armed && tick && (since != PER_EXP);
  assign timeout  = armed && !tick && !late && (since == PER_LATE);

  // Gap counter, arming and one-shot timeout tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap     <= '0;
      armed   <= 1'b0;
      late    <= 1'b0;
      per_err <= 1'b0;
    end else begin
      per_err <= bad_tick || timeout;
      if (tick) begin
        gap   <= '0;
        armed <= 1'b1;
        late  <= 1'b0;
      end else begin
        if (gap != '1) gap <= gap + 1'b1;
        if (timeout)   late <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_event_gen.sv
// Tick event generator: groups TICKS_PER_EVENT ticks into one event and
// presents it on a 4-phase req/ack handshake.
// Optional period monitor compiled in with TICK_EVENT_GEN_PERIOD_MON_EN.
module tick_event_gen
  import tick_event_pkg::*;
#(
  parameter int unsigned TICKS_PER_EVENT = 4,
  parameter int unsigned PERIOD          = 100001
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                ack,
  output logic                req,
  output logic                ovf,
  output logic [EVT_BITS-1:0] evt_cnt,
  output logic                per_err
);

  localparam logic [7:0] LAST_TICK = 8'(TICKS_PER_EVENT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] tcnt;
  logic       wrap;

  assign wrap = tick && (tcnt == LAST_TICK);

  // Handshake sequencing; ack is only looked at once a request is out.
  always_comb begin
    state_nxt = state;
    case (state)
      COUNT:   if (wrap) state_nxt = REQ;
      REQ:     if (ack)  state_nxt = DONE;
      DONE:    if (!ack) state_nxt = COUNT;
      default: state_nxt = COUNT;
    endcase
  end

  // State register with req registered alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COUNT;
      req   <= 1'b0;
    end else begin
      state <= state_nxt;
      req   <= (state_nxt == REQ);
    end
  end

  // Tick phase counter runs in every state so event phase survives a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
    end else if (tick) begin
      tcnt <= wrap ? '0 : tcnt + 1'b1;
    end
  end

  // Sticky drop flag: a tick group completed while the handshake was busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (wrap && (state != COUNT)) begin
      ovf <= 1'b1;
    end
  end

  // Completed handshake counter, free-running modulo 256.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_cnt <= '0;
    end else if ((state == REQ) && ack) begin
      evt_cnt <= evt_cnt + 1'b1;
    end
  end

`ifdef TICK_EVENT_GEN_PERIOD_MON_EN
  tick_period_mon #(
    .PERIOD(PERIOD)
  ) u_period_mon (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .per_err(per_err)
  );
`else
  // PERIOD has no consumer in this build; fold it into a deliberately unused net.
  localparam logic [GAP_BITS-1:0] PERIOD_W = GAP_BITS'(PERIOD);
  logic unused_period;
  assign unused_period = ^PERIOD_W;
  assign per_err       = 1'b0;
`endif

endmodule
